adsr_wave_generator: RTL
========================

ADSR_WAVE_GENERATOR -- requirements
Module: adsr_wave_generator

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of phase, envelope, rates, levels and output.
REQ-002 SHALL have parameter DIV_W, default 16, width of the frequency clock-divider counter.
REQ-003 clk  input  1  single clock (25 MHz nominal); all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 freq_select  input  3  frequency selection (8 levels).
REQ-006 wave_sel  input  2  00 sawtooth, 01 ramp-down, 10 square, 11 triangle.
REQ-007 attack_rate, decay_rate, release_rate  input  DATA_W each  clocks per envelope step minus 1.
REQ-008 sustain_level  input  DATA_W  envelope level held in SUSTAIN.
REQ-009 note_on, note_off  input  1 each  level-sampled note commands.
REQ-010 wave_out  output  DATA_W  registered, envelope-scaled waveform.
REQ-011 env_out  output  DATA_W  current envelope level.
REQ-012 busy  output  1  high when envelope state is not IDLE.

Function
REQ-013 Divider thresholds SHALL be 390, 195, 130, 98, 65, 49, 32, 24 for freq_select 0..7.
REQ-014 Divider: when clk_div >= threshold, clk_div <= 0 and phase <= phase+1 (mod 2^DATA_W); else clk_div <= clk_div+1; a threshold change mid-count takes effect on the next compare.
REQ-015 Raw waveform: saw = phase; ramp-down = ~phase; square = all-ones if phase MSB=1 else 0; triangle = (phase<<1) if MSB=0 else ~(phase<<1), truncated to DATA_W.
REQ-016 Envelope FSM states SHALL be IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-017 Step tick: prescaler counts 0..rate of current state; tick when prescaler == rate, then prescaler <= 0; rate 0 gives a tick every cycle; prescaler cleared on every state change.
REQ-018 IDLE: env = 0; note_on -> ATTACK.
REQ-019 ATTACK: env +1 per tick; on tick with env = all-ones-1, env <= all-ones and state -> DECAY; no overflow.
REQ-020 DECAY: env -1 per tick; when env <= sustain_level, env <= sustain_level and -> SUSTAIN (checked every cycle, sustain_level = all-ones exits immediately).
REQ-021 SUSTAIN: env follows sustain_level every cycle.
REQ-022 note_off in ATTACK, DECAY or SUSTAIN -> RELEASE next cycle, env continues from its current value.
REQ-023 RELEASE: env -1 per tick; when env = 0 -> IDLE; no underflow.
REQ-024 note_on in RELEASE -> ATTACK from current env (retrigger, no reset to 0); note_on in ATTACK/DECAY/SUSTAIN ignored.
REQ-025 note_on and note_off asserted together: note_off SHALL take priority in active states; in IDLE both are ignored.
REQ-026 wave_out SHALL be upper DATA_W bits of raw * (env+1), registered one cycle after raw and env; env = 0 gives 0, env = all-ones gives raw exactly.
REQ-027 env_out SHALL equal the env register; busy combinationally decoded from state.

Reset
REQ-028 On reset_n low, immediately: clk_div, phase, prescaler, env, wave_out = 0, state = IDLE, busy = 0, at any point including mid-note.
REQ-029 After reset_n rises, the first state change occurs no earlier than the first rising edge with note_on sampled high.

Verification
REQ-030 freq_select=3, wave_sel=00, env held max: phase increments every 99 clocks; wave_out wraps 255 -> 0 after 256 increments.
REQ-031 attack_rate=0, decay_rate=0, sustain_level=128, note_on one cycle: env reaches 255 after 255 clocks, descends to 128 after 127 more, state SUSTAIN, busy=1.
REQ-032 In SUSTAIN, note_off, release_rate=3: env decrements every 4 clocks to 0, then IDLE, busy=0.
REQ-033 Release at env=60, note_on: state ATTACK, env rises from 60, not 0.
REQ-034 note_on and note_off high together in DECAY: next state RELEASE; in IDLE: stays IDLE.
REQ-035 reset_n low mid-ATTACK with env=100: env, wave_out, phase = 0 without a clock edge; state IDLE.

Source files
------------

// File: rtl/adsr_wave_generator.sv
// ADSR envelope generator driving an envelope-scaled waveform.
// A programmable clock divider advances a phase accumulator, the phase is
// shaped into one of four raw waveforms, and the raw sample is scaled by a
// five-state ADSR envelope before being registered onto wave_out.
`timescale 1ns/1ps

module adsr_wave_generator #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        freq_select,
  input  logic [1:0]        wave_sel,
  input  logic [DATA_W-1:0] attack_rate,
  input  logic [DATA_W-1:0] decay_rate,
  input  logic [DATA_W-1:0] release_rate,
  input  logic [DATA_W-1:0] sustain_level,
  input  logic              note_on,
  input  logic              note_off,
  output logic [DATA_W-1:0] wave_out,
  output logic [DATA_W-1:0] env_out,
  output logic              busy
);

  localparam logic [DATA_W-1:0] VAL_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] VAL_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] VAL_MAX  = {DATA_W{1'b1}};
  localparam logic [DIV_W-1:0]  DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  logic [DIV_W-1:0]    clk_div_q, clk_div_d;
  logic [DIV_W-1:0]    threshold_s;
  logic [DATA_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0]   phase_shl_s;
  logic [DATA_W-1:0]   raw_s;
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   env_q, env_d;
  logic [DATA_W-1:0]   presc_q, presc_d;
  logic [DATA_W-1:0]   rate_s;
  logic                tick_s;
  logic [DATA_W:0]     env_inc_s;
  logic [2*DATA_W:0]   product_s;
  logic [DATA_W-1:0]   wave_q, wave_d;

  // Select the divider terminal count for the requested frequency.
  always_comb begin
    threshold_s = DIV_W'(16'd390);
    case (freq_select)
      3'd0:    threshold_s = DIV_W'(16'd390);
      3'd1:    threshold_s = DIV_W'(16'd195);
      3'd2:    threshold_s = DIV_W'(16'd130);
      3'd3:    threshold_s = DIV_W'(16'd98);
      3'd4:    threshold_s = DIV_W'(16'd65);
      3'd5:    threshold_s = DIV_W'(16'd49);
      3'd6:    threshold_s = DIV_W'(16'd32);
      3'd7:    threshold_s = DIV_W'(16'd24);
      default: threshold_s = DIV_W'(16'd390);
    endcase
  end

  // Divider next state: wrap the counter and advance phase on terminal count.
  always_comb begin
    clk_div_d = clk_div_q;
    phase_d   = phase_q;
    if (clk_div_q >= threshold_s) begin
      clk_div_d = DIV_ZERO;
      phase_d   = phase_q + VAL_ONE;
    end else begin
      clk_div_d = clk_div_q + DIV_ONE;
      phase_d   = phase_q;
    end
  end

  // Divider and phase accumulator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_div_q <= DIV_ZERO;
      phase_q   <= VAL_ZERO;
    end else begin
      clk_div_q <= clk_div_d;
      phase_q   <= phase_d;
    end
  end

  assign phase_shl_s = {phase_q[DATA_W-2:0], 1'b0};

  // Shape the phase into the selected raw waveform.
  always_comb begin
    raw_s = phase_q;
    case (wave_sel)
      2'b00:   raw_s = phase_q;
      2'b01:   raw_s = ~phase_q;
      2'b10:   raw_s = phase_q[DATA_W-1] ? VAL_MAX : VAL_ZERO;
      2'b11:   raw_s = phase_q[DATA_W-1] ? ~phase_shl_s : phase_shl_s;
      default: raw_s = phase_q;
    endcase
  end

  // Step rate of the current envelope segment; idle/sustain tick freely.
  always_comb begin
    rate_s = VAL_ZERO;
    case (state_q)
      ST_ATTACK:  rate_s = attack_rate;
      ST_DECAY:   rate_s = decay_rate;
      ST_RELEASE: rate_s = release_rate;
      default:    rate_s = VAL_ZERO;
    endcase
  end

  assign tick_s = (presc_q == rate_s);

  // Envelope FSM next state and envelope level; note_off wins over note_on.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      ST_IDLE: begin
        env_d = VAL_ZERO;
        if (note_on && !note_off) begin
          state_d = ST_ATTACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (note_off) begin
          state_d = ST_RELEASE;
        end else if (tick_s) begin
          // A retrigger can start at full scale, so clamp rather than wrap.
          if (env_q >= (VAL_MAX - VAL_ONE)) begin
            env_d   = VAL_MAX;
            state_d = ST_DECAY;
          end else begin
            env_d = env_q + VAL_ONE;
          end
        end else begin
          env_d = env_q;
        end
      end
      ST_DECAY: begin
        if (note_off) begin
          state_d = ST_RELEASE;
        end else if (env_q <= sustain_level) begin
          env_d   = sustain_level;
          state_d = ST_SUSTAIN;
        end else if (tick_s) begin
          // env_q > sustain_level here, so the decrement cannot underflow.
          if ((env_q - VAL_ONE) <= sustain_level) begin
            env_d   = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = env_q - VAL_ONE;
          end
        end else begin
          env_d = env_q;
        end
      end
      ST_SUSTAIN: begin
        if (note_off) begin
          state_d = ST_RELEASE;
        end else begin
          env_d = sustain_level;
        end
      end
      ST_RELEASE: begin
        if (note_on && !note_off) begin
          state_d = ST_ATTACK;
        end else if (env_q == VAL_ZERO) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          env_d = env_q - VAL_ONE;
          if (env_q == VAL_ONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          env_d = env_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = VAL_ZERO;
      end
    endcase
  end

  // Prescaler restarts on every tick and on every state change.
  always_comb begin
    presc_d = presc_q;
    if (state_d != state_q) begin
      presc_d = VAL_ZERO;
    end else if (tick_s) begin
      presc_d = VAL_ZERO;
    end else begin
      presc_d = presc_q + VAL_ONE;
    end
  end

  // Envelope state, level and prescaler registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      env_q   <= VAL_ZERO;
      presc_q <= VAL_ZERO;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      presc_q <= presc_d;
    end
  end

  // Scaling by env+1 makes full-scale envelope pass raw through unchanged.
  assign env_inc_s = {1'b0, env_q} + {{DATA_W{1'b0}}, 1'b1};
  assign product_s = {{(DATA_W+1){1'b0}}, raw_s} * {{DATA_W{1'b0}}, env_inc_s};

  // Keep the upper half of the product as the scaled sample.
  always_comb begin
    wave_d = DATA_W'(product_s >> DATA_W);
  end

  // Output sample register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wave_q <= VAL_ZERO;
    end else begin
      wave_q <= wave_d;
    end
  end

  assign wave_out = wave_q;
  assign env_out  = env_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
